// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion, 11 cycles per block.
// Optional macro AES_COMPLEMENTARY_OUT_EN adds inverted copies of the result and its valid strobe.
module aes128_encrypt_iter (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
`ifdef AES_COMPLEMENTARY_OUT_EN
  ,
  output logic [127:0] AES_data_out_complementary,
  output logic         AES_data_out_complementary_valid
`endif
);

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned LAST_ROUND = 10;

  typedef enum logic [0:0] {IDLE, RUN} fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [BLOCK_W-1:0]   state_q, state_d;
  logic [BLOCK_W-1:0]   rk_q, rk_d;
  logic [BLOCK_W-1:0]   out_d;
  logic                 valid_d;
  logic [BLOCK_W-1:0]   rk_next;
  logic [BLOCK_W-1:0]   sub_shifted;
  logic [BLOCK_W-1:0]   round_body;
  logic                 last_round;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as b^254 (= b^2 * b^4 * ... * b^128), then the affine transform; 0 maps to 0 before affine.
  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] sq;
    logic [BYTE_W-1:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BYTE_W-1:0] rcon(input logic [ROUND_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [BLOCK_W-1:0] key_step(input logic [BLOCK_W-1:0] rk,
                                                  input logic [ROUND_W-1:0] r);
    logic [WORD_W-1:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(r), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [BLOCK_W-1:0] sub_shift(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [BYTE_W-1:0]  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  assign last_round  = (round_q == ROUND_W'(LAST_ROUND));
  assign rk_next     = key_step(rk_q, round_q);
  assign sub_shifted = sub_shift(state_q);
  assign round_body  = last_round ? sub_shifted : mix_columns(sub_shifted);

  // Next-state and datapath update.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    rk_d    = rk_q;
    out_d   = AES_data_out;
    valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (AES_en) begin
          state_d = AES_data_in ^ AES_key_in;
          rk_d    = AES_key_in;
          round_d = ROUND_W'(1);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        rk_d    = rk_next;
        state_d = round_body ^ rk_next;
        round_d = round_q + ROUND_W'(1);
        if (last_round) begin
          out_d   = round_body ^ rk_next;
          valid_d = 1'b1;
          round_d = '0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      fsm_q              <= IDLE;
      round_q            <= '0;
      state_q            <= '0;
      rk_q               <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      fsm_q              <= fsm_d;
      round_q            <= round_d;
      state_q            <= state_d;
      rk_q               <= rk_d;
      AES_data_out       <= out_d;
      AES_data_out_valid <= valid_d;
    end
  end

`ifdef AES_COMPLEMENTARY_OUT_EN
  // Inverted twin of the result registers, loaded on the same edge.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      AES_data_out_complementary       <= '1;
      AES_data_out_complementary_valid <= 1'b0;
    end else begin
      AES_data_out_complementary       <= ~out_d;
      AES_data_out_complementary_valid <= valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed self-checking bench for aes128_encrypt_iter using FIPS-197 known-answer vectors.
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic [127:0] data_out;
  logic         valid;
`ifdef AES_COMPLEMENTARY_OUT_EN
  logic [127:0] data_out_c;
  logic         valid_c;
`endif

  int total = 0;
  int bad = 0;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_encrypt_iter dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_data_out       (data_out),
    .AES_data_out_valid (valid)
`ifdef AES_COMPLEMENTARY_OUT_EN
    ,
    .AES_data_out_complementary       (data_out_c),
    .AES_data_out_complementary_valid (valid_c)
`endif
  );

  always #5 clk = ~clk;

  // Waits up to budget edges for valid; lat = edges waited, -1 if it never came.
  task automatic wait_valid(input int budget, output int lat);
    int k;
    lat = -1;
    k = 0;
    while (lat < 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (valid) lat = k;
    end
  endtask

  // Called #1 after an edge; returns #1 after the acceptance edge with en low.
  task automatic pulse_start(input logic [127:0] pt, input logic [127:0] key);
    data_in = pt;
    key_in  = key;
    en      = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (data_out !== 128'h0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got out=%h valid=%b want out=0 valid=0", i, data_out, valid);
      end
`ifdef AES_COMPLEMENTARY_OUT_EN
      total++;
      if (data_out_c !== {128{1'b1}} || valid_c !== 1'b0) begin
        bad++;
        $display("FAIL reset_comp[%0d]: got out=%h valid=%b want all ones, 0", i, data_out_c, valid_c);
      end
`endif
      en = ~en;
    end
    en  = 1'b0;
    rst = 1'b0;
    pulse_start(PT_C1, KEY_C1);
    wait_valid(15, lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL reset_latency: got %0d want 10", lat);
    end
    total++;
    if (data_out !== CT_C1) begin
      bad++;
      $display("FAIL fips_c1_result: got %h want %h", data_out, CT_C1);
    end
    @(posedge clk); #1;
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL fips_c1_single_pulse: got valid=%b want 0", valid);
    end
  endtask

  task automatic test_vector(input string name, input logic [127:0] pt,
                             input logic [127:0] key, input logic [127:0] ct);
    int lat;
    pulse_start(pt, key);
    wait_valid(15, lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL %s_latency: got %0d want 10", name, lat);
    end
    total++;
    if (data_out !== ct) begin
      bad++;
      $display("FAIL %s_result: got %h want %h", name, data_out, ct);
    end
`ifdef AES_COMPLEMENTARY_OUT_EN
    total++;
    if (data_out_c !== ~ct || valid_c !== 1'b1) begin
      bad++;
      $display("FAIL %s_comp: got %h valid=%b want %h valid=1", name, data_out_c, valid_c, ~ct);
    end
`endif
    @(posedge clk); #1;
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_single_pulse: got valid=%b want 0", name, valid);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last_edge;
    int lat;
    pulses    = 0;
    last_edge = -1;
    data_in   = PT_B;
    key_in    = KEY_B;
    en        = 1'b1;
    for (int cyc = 0; cyc <= 50; cyc++) begin
      @(posedge clk); #1;
      if (valid) begin
        pulses++;
        total++;
        if (data_out !== CT_B) begin
          bad++;
          $display("FAIL b2b_result@%0d: got %h want %h", cyc, data_out, CT_B);
        end
        total++;
        if ((last_edge < 0 && cyc != 10) || (last_edge >= 0 && cyc - last_edge != 11)) begin
          bad++;
          $display("FAIL b2b_spacing: got pulse at edge %0d after %0d, want first at 10 then every 11",
                   cyc, last_edge);
        end
        last_edge = cyc;
      end
    end
    total++;
    if (pulses != 4) begin
      bad++;
      $display("FAIL b2b_pulse_count: got %0d want 4", pulses);
    end
    // Block accepted at edge 44 must still finish after en drops at edge 50.
    en = 1'b0;
    wait_valid(10, lat);
    total++;
    if (lat !== 4 || data_out !== CT_B) begin
      bad++;
      $display("FAIL b2b_drain: got lat=%0d out=%h want lat=4 out=%h", lat, data_out, CT_B);
    end
  endtask

  task automatic test_idle_hold();
    data_in = PT_C1;
    key_in  = KEY_C1;
    en      = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      total++;
      if (valid !== 1'b0 || data_out !== CT_B) begin
        bad++;
        $display("FAIL idle_hold[%0d]: got out=%h valid=%b want out=%h valid=0", i, data_out, valid, CT_B);
      end
    end
  endtask

  task automatic test_mid_change();
    int lat;
    pulse_start(PT_C1, KEY_C1);
    repeat (5) @(posedge clk);
    #1;
    data_in = PT_B;
    key_in  = 128'h0;
    wait_valid(10, lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL mid_change_latency: got %0d want 5", lat);
    end
    total++;
    if (data_out !== CT_C1) begin
      bad++;
      $display("FAIL mid_change_result: got %h want %h", data_out, CT_C1);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int pulses;
    pulse_start(128'h0, 128'h0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (data_out !== 128'h0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_clear: got out=%h valid=%b want out=0 valid=0", data_out, valid);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    total++;
    if (pulses != 0 || data_out !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset_abort: got pulses=%0d out=%h want pulses=0 out=0", pulses, data_out);
    end
    pulse_start(PT_B, KEY_B);
    wait_valid(15, lat);
    total++;
    if (lat !== 10 || data_out !== CT_B) begin
      bad++;
      $display("FAIL mid_reset_restart: got lat=%0d out=%h want lat=10 out=%h", lat, data_out, CT_B);
    end
  endtask

  initial begin
    test_reset();
    test_vector("fips_b", PT_B, KEY_B, CT_B);
    test_vector("zero", 128'h0, 128'h0, CT_Z);
    test_back_to_back();
    test_idle_hold();
    test_mid_change();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
Iterative AES-128 encryption core (FIPS-197 cipher only). Computes one round per clock with on-the-fly key expansion, taking 11 cycles per block. It is the top-level crypto block. It accepts one 128-bit plaintext and key per start and returns the ciphertext with a one-cycle valid strobe.

Parameters:
None. Nr = 10 and Nk = 4 are fixed by AES-128.

Ports:
AES_clk  input  1  rising-edge clock
AES_rst  input  1  asynchronous reset, active-high
AES_en  input  1  start request, level-sensitive; sampled only while idle
AES_data_in  input  128  plaintext; bits [127:120] = byte 0 (FIPS-197 input order)
AES_key_in  input  128  cipher key, same byte order
AES_data_out  output  128  ciphertext; holds the last result
AES_data_out_valid  output  1  one-cycle strobe marking a new AES_data_out

Behaviour:
- Reset (async, AES_rst=1):
  - FSM goes to IDLE and round counter = 0.
  - State and round-key registers = 0.
  - AES_data_out = 0, AES_data_out_valid = 0.
  - Reset asserted mid-encryption aborts the operation. No valid is produced for the aborted block.
- FSM states: IDLE and RUN.
- IDLE:
  - On a rising edge with AES_en=1, capture state = AES_data_in ^ AES_key_in (initial AddRoundKey) and round key = AES_key_in.
  - Set round counter = 1 and go to RUN. Call this edge E0.
- RUN, edges E1..E10 (round r = counter):
  - Compute next round key r: RotWord, SubWord, Rcon[r] = 01,02,04,08,10,20,40,80,1b,36 on word 3, then XOR chain w0..w3.
  - Compute state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_r).
  - Omit MixColumns when r = 10.
  - Increment the counter.
- At E10:
  - AES_data_out <= final state.
  - AES_data_out_valid = 1 for exactly the cycle E10..E11.
  - FSM returns to IDLE.
- Latency and throughput:
  - Latency: valid rises 10 edges after the acceptance edge.
  - Throughput: one block per 11 cycles.
  - If AES_en is still high at E11, a new block is accepted at E11. Holding AES_en high therefore re-encrypts continuously with whatever inputs are present at each acceptance edge.
- Input sampling:
  - AES_data_in and AES_key_in are sampled only at the acceptance edge.
  - Changes during RUN or while AES_en=0 have no effect.
- AES_en behaviour:
  - Deasserting AES_en during RUN does not abort the block.
  - AES_en=0 in IDLE keeps the core idle and leaves the outputs unchanged.
- AES_data_out keeps its value until the next completion or reset.
- Valid is never asserted other than at completion.
- Datapath:
  - 16 state S-boxes plus 4 key-schedule S-boxes, all combinational.
  - S-box implemented either as a 256-entry function or as GF(2^8) inverse plus affine transform. The results must be identical.
  - MixColumns uses xtime: {02}·b = (b<<1) ^ (b[7] ? 8'h1b : 0).
- Column layout: column c = bits [127-32c : 96-32c]. ShiftRows rotates row i left by i columns.

Optional Feature:
Macro AES_COMPLEMENTARY_OUT_EN.
- Defined: adds two outputs.
  - AES_data_out_complementary, 128 bits: always the bitwise inverse of AES_data_out, including 128'hFF..FF while in reset.
  - AES_data_out_complementary_valid, 1 bit: identical timing to AES_data_out_valid.
  - Both are registered in the same edge as the true outputs. They serve as a fault-detection / power-balancing aid.
- Undefined: neither port exists and behaviour is otherwise unchanged.

Test Plan:
- Reset: hold AES_rst=1 for 2 cycles and toggle AES_en -> AES_data_out=0, valid=0 throughout. Release, then one pulse of AES_en -> valid exactly 10 edges later.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a, single-cycle valid.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Continuous run: AES_en held high for 51 cycles with constant inputs -> valid pulses every 11 cycles with the same ciphertext. Change AES_data_in while AES_en=0 -> AES_data_out unchanged, no valid.
- Mid-operation: change inputs at E5 -> result matches the inputs captured at E0. Assert AES_rst at E5 -> outputs cleared, no valid, and the next start completes correctly.
